pipe_stall_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage 32-bit pipeline.
- Arbitrates four pipeline-control sources each cycle:
  - data-memory wait
  - the multi-cycle multiply/divide unit handshake
  - EX-stage taken-branch flush
  - ID-stage load-use hazard
- Drives the PC, IF/ID and ID/EX control enables. Keeps saturating stall and flush counters for performance debug.

---
 rtl/pipe_stall_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: arbitrates data-memory wait,
// the multi-cycle mult/div handshake, EX branch flush and ID load-use hazard.
// Control outputs are combinational from state and current inputs.
module pipe_stall_ctrl #(
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_ex_mem_read,
    input  logic [4:0]       id_ex_rt,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic             ex_branch_taken,
    input  logic             ex_md_start,
    input  logic             md_done,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             pipe_hold_ex,
    output logic             md_go,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int unsigned      TO_W    = $clog2(MD_TIMEOUT);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(MD_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [0:0] {StRun, StMdWait} state_e;

    state_e            state_q, state_d;
    logic [TO_W-1:0]   tcnt_q, tcnt_d;
    logic              md_err_q, md_err_d;
    logic [CNT_W-1:0]  stall_count_q, flush_count_q;
    logic              load_use;
    logic              mem_stall;

    // Register zero is hardwired, so a load to it never creates a hazard.
    assign load_use = id_ex_mem_read && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) || (if_id_uses_rt && (id_ex_rt == if_id_rt)));
    assign mem_stall = mem_req && !mem_ready;

    assign md_err      = md_err_q;
    assign stall_count = stall_count_q;
    assign flush_count = flush_count_q;

    // Prioritised control decode and next-state/timeout logic.
    always_comb begin
        pc_write     = 1'b1;
        ifid_write   = 1'b1;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        pipe_hold_ex = 1'b0;
        md_go        = 1'b0;
        state_d      = state_q;
        tcnt_d       = tcnt_q;
        md_err_d     = md_err_q;
        if (!reset) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (mem_stall) begin
                        // Branch and md start stay frozen in EX and are seen again next cycle.
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        pipe_hold_ex = 1'b1;
                    end else if (ex_md_start) begin
                        md_go        = 1'b1;
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        pipe_hold_ex = 1'b1;
                        state_d      = StMdWait;
                        tcnt_d       = '0;
                    end else if (ex_branch_taken) begin
                        // The instruction in ID is squashed, so any load-use on it is moot.
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                    end else if (load_use) begin
                        pc_write    = 1'b0;
                        ifid_write  = 1'b0;
                        idex_bubble = 1'b1;
                    end
                end
                StMdWait: begin
                    if (mem_stall || !md_done) begin
                        pc_write     = 1'b0;
                        ifid_write   = 1'b0;
                        pipe_hold_ex = 1'b1;
                        if (tcnt_q == TO_LAST) begin
                            md_err_d = 1'b1;
                            state_d  = StRun;
                            tcnt_d   = '0;
                        end else begin
                            tcnt_d = tcnt_q + 1'b1;
                        end
                    end else begin
                        state_d = StRun;
                    end
                end
                default: state_d = StRun;
            endcase
        end
    end

    // State, timeout and saturating performance counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= StRun;
            tcnt_q        <= '0;
            md_err_q      <= 1'b0;
            stall_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            state_q  <= state_d;
            tcnt_q   <= tcnt_d;
            md_err_q <= md_err_d;
            if (!pc_write && (stall_count_q != CNT_MAX)) begin
                stall_count_q <= stall_count_q + 1'b1;
            end
            if (ifid_flush && (flush_count_q != CNT_MAX)) begin
                flush_count_q <= flush_count_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios plus a randomized
// run against a behavioural model of the stall/flush rules.
module tb_pipe_stall_ctrl;

    localparam int unsigned CNT_W      = 8;
    localparam int unsigned MD_TIMEOUT = 64;
    localparam int          CNT_MAX    = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             id_ex_mem_read, if_id_uses_rt;
    logic [4:0]       id_ex_rt, if_id_rs, if_id_rt;
    logic             ex_branch_taken, ex_md_start, md_done, mem_req, mem_ready;
    logic             pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold_ex, md_go;
    logic             md_err;
    logic [CNT_W-1:0] stall_count, flush_count;

    int checks = 0;
    int failures = 0;

    pipe_stall_ctrl #(
        .CNT_W      (CNT_W),
        .MD_TIMEOUT (MD_TIMEOUT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .id_ex_mem_read  (id_ex_mem_read),
        .id_ex_rt        (id_ex_rt),
        .if_id_rs        (if_id_rs),
        .if_id_rt        (if_id_rt),
        .if_id_uses_rt   (if_id_uses_rt),
        .ex_branch_taken (ex_branch_taken),
        .ex_md_start     (ex_md_start),
        .md_done         (md_done),
        .mem_req         (mem_req),
        .mem_ready       (mem_ready),
        .pc_write        (pc_write),
        .ifid_write      (ifid_write),
        .ifid_flush      (ifid_flush),
        .idex_bubble     (idex_bubble),
        .pipe_hold_ex    (pipe_hold_ex),
        .md_go           (md_go),
        .md_err          (md_err),
        .stall_count     (stall_count),
        .flush_count     (flush_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        id_ex_mem_read  = 1'b0;
        id_ex_rt        = 5'd0;
        if_id_rs        = 5'd0;
        if_id_rt        = 5'd0;
        if_id_uses_rt   = 1'b0;
        ex_branch_taken = 1'b0;
        ex_md_start     = 1'b0;
        md_done         = 1'b0;
        mem_req         = 1'b0;
        mem_ready       = 1'b0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        ex_md_start = 1'b1;
        ex_branch_taken = 1'b1;
        mem_req = 1'b1;
        #1;
        checks++;
        if ({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold_ex, md_go} !== 6'b000100) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 000100",
                     {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold_ex, md_go});
        end
        tick();
        set_idle();
        reset = 1'b1;
        checks++;
        if (stall_count !== 0 || flush_count !== 0 || md_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_regs: got stall=%0d flush=%0d err=%0d expected 0 0 0",
                     stall_count, flush_count, md_err);
        end
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_run: got pc_write=%0d bubble=%0d expected 1 0",
                     pc_write, idex_bubble);
        end
    endtask

    task automatic test_load_use();
        do_reset();
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd5;
        if_id_rs = 5'd5;
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b0 || ifid_write !== 1'b0 || idex_bubble !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall: got pc=%0d ifw=%0d bub=%0d expected 0 0 1",
                     pc_write, ifid_write, idex_bubble);
        end
        tick();
        set_idle();
        checks++;
        if (stall_count !== 8'd1) begin
            failures++;
            $display("FAIL load_use_count: got %0d expected 1", stall_count);
        end
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd0;
        if_id_rs = 5'd0;
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b1 || idex_bubble !== 1'b0) begin
            failures++;
            $display("FAIL load_use_r0: got pc=%0d bub=%0d expected 1 0", pc_write, idex_bubble);
        end
        tick();
        set_idle();
        checks++;
        if (stall_count !== 8'd1) begin
            failures++;
            $display("FAIL load_use_r0_count: got %0d expected 1", stall_count);
        end
    endtask

    task automatic test_branch_over_load_use();
        do_reset();
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd7;
        if_id_rs = 5'd3;
        if_id_rt = 5'd7;
        if_id_uses_rt = 1'b1;
        ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (ifid_flush !== 1'b1 || idex_bubble !== 1'b1 || pc_write !== 1'b1) begin
            failures++;
            $display("FAIL branch_flush: got flush=%0d bub=%0d pc=%0d expected 1 1 1",
                     ifid_flush, idex_bubble, pc_write);
        end
        tick();
        set_idle();
        checks++;
        if (flush_count !== 8'd1 || stall_count !== 8'd0) begin
            failures++;
            $display("FAIL branch_counts: got flush=%0d stall=%0d expected 1 0",
                     flush_count, stall_count);
        end
    endtask

    task automatic test_md_handshake();
        do_reset();
        ex_md_start = 1'b1;
        @(negedge clk);
        checks++;
        if (md_go !== 1'b1 || pc_write !== 1'b0 || pipe_hold_ex !== 1'b1) begin
            failures++;
            $display("FAIL md_go_issue: got go=%0d pc=%0d hold=%0d expected 1 0 1",
                     md_go, pc_write, pipe_hold_ex);
        end
        tick();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (md_go !== 1'b0 || pc_write !== 1'b0 || pipe_hold_ex !== 1'b1) begin
                failures++;
                $display("FAIL md_wait_%0d: got go=%0d pc=%0d hold=%0d expected 0 0 1",
                         i, md_go, pc_write, pipe_hold_ex);
            end
            tick();
        end
        ex_md_start = 1'b0;
        md_done = 1'b1;
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b1 || pipe_hold_ex !== 1'b0 || md_go !== 1'b0) begin
            failures++;
            $display("FAIL md_done_release: got pc=%0d hold=%0d go=%0d expected 1 0 0",
                     pc_write, pipe_hold_ex, md_go);
        end
        tick();
        checks++;
        if (stall_count !== 8'd5) begin
            failures++;
            $display("FAIL md_stall_count: got %0d expected 5", stall_count);
        end
        // A stray md_done in RUN must not disturb the pipeline.
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b1 || md_go !== 1'b0 || pipe_hold_ex !== 1'b0) begin
            failures++;
            $display("FAIL md_done_in_run: got pc=%0d go=%0d hold=%0d expected 1 0 0",
                     pc_write, md_go, pipe_hold_ex);
        end
        tick();
        set_idle();
    endtask

    task automatic test_md_timeout();
        int bad;
        do_reset();
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        bad = 0;
        for (int i = 0; i < MD_TIMEOUT; i++) begin
            @(negedge clk);
            if (pc_write !== 1'b0 || md_err !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL md_timeout_hold: got %0d bad held cycles expected 0", bad);
        end
        checks++;
        if (md_err !== 1'b1) begin
            failures++;
            $display("FAIL md_timeout_err: got %0d expected 1", md_err);
        end
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b1 || pipe_hold_ex !== 1'b0) begin
            failures++;
            $display("FAIL md_timeout_resume: got pc=%0d hold=%0d expected 1 0",
                     pc_write, pipe_hold_ex);
        end
        tick();
        tick();
        checks++;
        if (md_err !== 1'b1 || stall_count !== 8'(MD_TIMEOUT + 1)) begin
            failures++;
            $display("FAIL md_timeout_sticky: got err=%0d stall=%0d expected 1 %0d",
                     md_err, stall_count, MD_TIMEOUT + 1);
        end
        do_reset();
        checks++;
        if (md_err !== 1'b0) begin
            failures++;
            $display("FAIL md_err_clear: got %0d expected 0", md_err);
        end
    endtask

    task automatic test_mem_stall_branch();
        do_reset();
        mem_req = 1'b1;
        mem_ready = 1'b0;
        ex_branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (pc_write !== 1'b0 || pipe_hold_ex !== 1'b1 || ifid_flush !== 1'b0) begin
                failures++;
                $display("FAIL mem_stall_%0d: got pc=%0d hold=%0d flush=%0d expected 0 1 0",
                         i, pc_write, pipe_hold_ex, ifid_flush);
            end
            tick();
        end
        mem_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (ifid_flush !== 1'b1 || pc_write !== 1'b1) begin
            failures++;
            $display("FAIL mem_ready_flush: got flush=%0d pc=%0d expected 1 1", ifid_flush, pc_write);
        end
        tick();
        set_idle();
        checks++;
        if (stall_count !== 8'd3 || flush_count !== 8'd1) begin
            failures++;
            $display("FAIL mem_stall_counts: got stall=%0d flush=%0d expected 3 1",
                     stall_count, flush_count);
        end
    endtask

    task automatic test_reset_mid_md();
        do_reset();
        ex_md_start = 1'b1;
        tick();
        ex_md_start = 1'b0;
        tick();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (pc_write !== 1'b0 || idex_bubble !== 1'b1 || md_go !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_md_%0d: got pc=%0d bub=%0d go=%0d expected 0 1 0",
                         i, pc_write, idex_bubble, md_go);
            end
            tick();
        end
        reset = 1'b1;
        checks++;
        if (stall_count !== 0 || flush_count !== 0) begin
            failures++;
            $display("FAIL reset_mid_md_counts: got stall=%0d flush=%0d expected 0 0",
                     stall_count, flush_count);
        end
        @(negedge clk);
        checks++;
        if (pc_write !== 1'b1 || md_go !== 1'b0 || pipe_hold_ex !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_md_run: got pc=%0d go=%0d hold=%0d expected 1 0 0",
                     pc_write, md_go, pipe_hold_ex);
        end
        tick();
    endtask

    task automatic test_saturation();
        do_reset();
        id_ex_mem_read = 1'b1;
        id_ex_rt = 5'd9;
        if_id_rs = 5'd9;
        for (int i = 0; i < CNT_MAX + 5; i++) tick();
        checks++;
        if (stall_count !== 8'(CNT_MAX)) begin
            failures++;
            $display("FAIL stall_saturate: got %0d expected %0d", stall_count, CNT_MAX);
        end
        set_idle();
        ex_branch_taken = 1'b1;
        for (int i = 0; i < CNT_MAX + 5; i++) tick();
        checks++;
        if (flush_count !== 8'(CNT_MAX) || stall_count !== 8'(CNT_MAX)) begin
            failures++;
            $display("FAIL flush_saturate: got flush=%0d stall=%0d expected %0d %0d",
                     flush_count, stall_count, CNT_MAX, CNT_MAX);
        end
        set_idle();
    endtask

    // Reference model: the arbitration is expressed as an action chosen per cycle.
    typedef enum int {ActReset, ActFreeze, ActMdGo, ActFlush, ActBubble, ActAdvance} act_e;

    bit m_wait;
    int m_tcnt, m_stall, m_flush;
    bit m_err;

    function automatic act_e model_action();
        bit ms, lu;
        ms = mem_req && !mem_ready;
        lu = id_ex_mem_read && id_ex_rt != 0 &&
             (id_ex_rt == if_id_rs || (if_id_uses_rt && id_ex_rt == if_id_rt));
        if (!reset) return ActReset;
        if (m_wait) return (ms || !md_done) ? ActFreeze : ActAdvance;
        if (ms) return ActFreeze;
        if (ex_md_start) return ActMdGo;
        if (ex_branch_taken) return ActFlush;
        if (lu) return ActBubble;
        return ActAdvance;
    endfunction

    // Output vector {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold_ex, md_go}.
    function automatic logic [5:0] action_outputs(act_e a);
        case (a)
            ActFreeze: return 6'b000010;
            ActMdGo:   return 6'b000011;
            ActFlush:  return 6'b111100;
            ActAdvance: return 6'b110000;
            default:   return 6'b000100;
        endcase
    endfunction

    task automatic test_random();
        act_e a;
        logic [5:0] exp;
        do_reset();
        m_wait = 0; m_tcnt = 0; m_stall = 0; m_flush = 0; m_err = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            reset           = ($urandom_range(299) != 0);
            id_ex_mem_read  = ($urandom_range(99) < 40);
            id_ex_rt        = 5'($urandom_range(3));
            if_id_rs        = 5'($urandom_range(3));
            if_id_rt        = 5'($urandom_range(3));
            if_id_uses_rt   = ($urandom_range(1) == 1);
            ex_branch_taken = ($urandom_range(99) < 20);
            ex_md_start     = ($urandom_range(99) < 10);
            md_done         = ($urandom_range(99) < 8);
            mem_req         = ($urandom_range(99) < 40);
            mem_ready       = ($urandom_range(99) < 50);
            a = model_action();
            exp = action_outputs(a);
            @(negedge clk);
            checks++;
            if ({pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold_ex, md_go} !== exp) begin
                failures++;
                $display("FAIL rand_ctrl cyc=%0d: got %b expected %b", cyc,
                         {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold_ex, md_go}, exp);
            end
            checks++;
            if (md_err !== m_err || int'(stall_count) != m_stall || int'(flush_count) != m_flush) begin
                failures++;
                $display("FAIL rand_regs cyc=%0d: got err=%0d stall=%0d flush=%0d expected %0d %0d %0d",
                         cyc, md_err, stall_count, flush_count, m_err, m_stall, m_flush);
            end
            tick();
            if (a == ActReset) begin
                m_wait = 0; m_tcnt = 0; m_stall = 0; m_flush = 0; m_err = 0;
            end else begin
                if (!exp[5] && m_stall < CNT_MAX) m_stall++;
                if (exp[3] && m_flush < CNT_MAX) m_flush++;
                if (a == ActMdGo) begin
                    m_wait = 1;
                    m_tcnt = 0;
                end else if (m_wait) begin
                    if (a == ActFreeze) begin
                        if (m_tcnt == MD_TIMEOUT - 1) begin
                            m_err = 1;
                            m_wait = 0;
                        end else begin
                            m_tcnt++;
                        end
                    end else begin
                        m_wait = 0;
                    end
                end
            end
        end
        set_idle();
        reset = 1'b1;
    endtask

    initial begin
        set_idle();
        test_reset();
        test_load_use();
        test_branch_over_load_use();
        test_md_handshake();
        test_md_timeout();
        test_mem_stall_branch();
        test_reset_mid_md();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
